// File: rtl/small_calc_cu.sv
// Moore control unit for the 4-bit small-calculator datapath: loads two operands,
// runs the requested ALU op into the result register, then presents it with done.
module small_calc_cu #(
    parameter logic [1:0] A_ADDR  = 2'b01,
    parameter logic [1:0] B_ADDR  = 2'b10,
    parameter logic [1:0] R_ADDR  = 2'b11,
    parameter logic [1:0] PASS_OP = 2'b10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic [1:0] op,
    output logic [1:0] s1,
    output logic [1:0] wa,
    output logic       we,
    output logic [1:0] raa,
    output logic       rea,
    output logic [1:0] rab,
    output logic       reb,
    output logic [1:0] c,
    output logic       s2,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        EXEC   = 3'd3,
        OUTPUT = 3'd4,
        DONE   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] op_q, op_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        op_d    = op_q;
        s1      = 2'b00;
        wa      = 2'b00;
        we      = 1'b0;
        raa     = 2'b00;
        rea     = 1'b0;
        rab     = 2'b00;
        reb     = 1'b0;
        c       = 2'b00;
        s2      = 1'b0;
        done    = 1'b0;
        busy    = 1'b1;
        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (go) begin
                    op_d    = op;
                    state_d = LOAD_A;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_A: begin
                s1      = 2'b00;
                wa      = A_ADDR;
                we      = 1'b1;
                state_d = LOAD_B;
            end
            LOAD_B: begin
                s1      = 2'b01;
                wa      = B_ADDR;
                we      = 1'b1;
                state_d = EXEC;
            end
            EXEC: begin
                rea     = 1'b1;
                reb     = 1'b1;
                raa     = A_ADDR;
                rab     = B_ADDR;
                c       = op_q;
                s1      = 2'b11;
                wa      = R_ADDR;
                we      = 1'b1;
                state_d = OUTPUT;
            end
            OUTPUT: begin
                // R AND R passes the stored result through the ALU unchanged
                rea     = 1'b1;
                reb     = 1'b1;
                raa     = R_ADDR;
                rab     = R_ADDR;
                c       = PASS_OP;
                s2      = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                rea     = 1'b1;
                reb     = 1'b1;
                raa     = R_ADDR;
                rab     = R_ADDR;
                c       = PASS_OP;
                s2      = 1'b1;
                done    = 1'b1;
                state_d = go ? DONE : IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: doc/small_calc_cu.md
Name: small_calc_cu

Overview:
Control unit for the 4-bit small-calculator datapath (small_calc_DP); it is the other end of that datapath's control interface.
- Drives the datapath control pins (s1, wa, we, raa, rea, rab, reb, c, s2) from a Moore FSM.
- Per go/done request: loads in1 and in2 into the register file, runs the ALU with the requested op, writes the result back, then presents it on the datapath output.
- Sits beside small_calc_DP in the small-calculator top level; the top level wires port names 1:1.

Parameters:
A_ADDR, 2'b01, RF address receiving operand in1
B_ADDR, 2'b10, RF address receiving operand in2
R_ADDR, 2'b11, RF address receiving the ALU result
PASS_OP, 2'b10, ALU code used to present the result (bitwise AND of R with itself = R)

Ports:
clk  input  1  clock, all state changes on rising edge
rst  input  1  asynchronous, active-high reset
go  input  1  request; 4-phase handshake with done
op  input  2  ALU operation code for this request, sampled when go is accepted
s1  output  2  datapath input mux select (00 in1, 01 in2, 10 zero, 11 aluout)
wa  output  2  RF write address
we  output  1  RF write enable
raa  output  2  RF read address A
rea  output  1  RF read enable A
rab  output  2  RF read address B
reb  output  1  RF read enable B
c  output  2  ALU operation code
s2  output  1  output mux select (1 = aluout, 0 = 4'b0000)
done  output  1  result valid on datapath out
busy  output  1  high in every state except IDLE

Behaviour:
- State register: IDLE, LOAD_A, LOAD_B, EXEC, OUTPUT, DONE. Internal op_r[1:0].
- All outputs decode combinationally from state (and op_r). Default value of every output is 0 (s1=00, wa=00, raa=00, rab=00, c=00, we=rea=reb=s2=done=0).
- Reset: rst high forces IDLE and op_r=00 immediately, regardless of clk. All outputs go to defaults. This also applies mid-operation; any RF write in flight is dropped, since we falls with the state.
- IDLE: defaults. If go=1 at the clk edge, latch op into op_r and go to LOAD_A; otherwise stay.
- LOAD_A: s1=00, wa=A_ADDR, we=1. Next state LOAD_B.
- LOAD_B: s1=01, wa=B_ADDR, we=1. Next state EXEC.
- EXEC: rea=reb=1, raa=A_ADDR, rab=B_ADDR, c=op_r, s1=11, wa=R_ADDR, we=1. Next state OUTPUT.
- OUTPUT: rea=reb=1, raa=rab=R_ADDR, c=PASS_OP, s2=1. Next state DONE.
- DONE: same datapath controls as OUTPUT, plus done=1. Stay while go=1; go to IDLE at the first edge where go=0.
- Latency: go sampled in IDLE at edge 0 gives done=1 after edge 4 (four cycles). The datapath out equals the result while done=1.
- The op input is ignored outside IDLE; changes while busy have no effect on the current request.
- go held high continuously: the block completes exactly one request and waits in DONE. A new request needs go to fall, then rise again in IDLE. The minimum go-low time is one cycle.
- Result width: 4 bits. ALU overflow/carry is discarded by the datapath; the CU does not flag it.
- Illegal state encodings recover to IDLE on the next edge with default outputs.
- RF addr 2'b00 is never written or read by this block.

Test Plan:
1. Reset: assert rst mid-clock with no edge -> all outputs 0, busy=0 immediately; release and hold go=0 for 5 cycles -> state stays IDLE, outputs unchanged.
2. Add: in1=4'd3, in2=4'd5, op=00 (add), pulse go high and keep it high -> over consecutive cycles, controls follow the LOAD_A, LOAD_B, EXEC pattern. At EXEC: we=1, wa=11, c=00. At edge 4: done=1 and DP out=4'd8. Drop go -> IDLE next edge, done=0, out=0.
3. Wrap: in1=4'd12, in2=4'd7, op=00 -> out=4'd3 (carry dropped), done=1 after four cycles.
4. Op latch: go with op=01 (sub), in1=9, in2=4; change op to 00 in LOAD_A -> EXEC shows c=01 and out=4'd5.
5. Reset mid-op: assert rst during EXEC -> we=0 and IDLE immediately. After release, a new request in1=2, in2=2, op=10 -> out=4'd2, done=1 after four cycles.
6. Held go: keep go=1 for 20 cycles -> exactly one pass through LOAD_A, busy stays 1, done stays 1. Drop go for one cycle, then raise it -> a second full sequence starts from IDLE.
